// File: rtl/cache_2way_mc.sv
// 2-way set-associative, write-through, no-write-allocate data cache with
// per-set LRU replacement, byte-enable store merging and a full flush sweep.
module cache_2way_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CACHE_SIZE = 4096,
  parameter int LINE_SIZE  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_valid,
  input  logic                    cpu_we,
  input  logic [DATA_WIDTH/8-1:0] cpu_be,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_w_data,
  input  logic                    flush,
  output logic [DATA_WIDTH-1:0]   cpu_r_data,
  output logic                    cpu_ready,
  output logic                    cache_hit,
  output logic                    flush_busy,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_w_data,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_r_data
);

  localparam int BYTES       = DATA_WIDTH / 8;
  localparam int SETS        = CACHE_SIZE / (2 * LINE_SIZE);
  localparam int WPL         = LINE_SIZE / BYTES;
  localparam int OFFSET_BITS = $clog2(LINE_SIZE);
  localparam int INDEX_BITS  = $clog2(SETS);
  localparam int TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int BYTE_BITS   = $clog2(BYTES);
  localparam int WORD_BITS   = $clog2(WPL);

  typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;

  state_t                  state;
  logic [WORD_BITS-1:0]    fill_cnt;
  logic [INDEX_BITS-1:0]   sweep;
  logic [ADDR_WIDTH-1:0]   base_addr;
  logic [WORD_BITS-1:0]    fill_word;
  logic                    victim;
  logic                    pending;

  logic [DATA_WIDTH-1:0]   data_mem [2][SETS][WPL];
  logic [TAG_BITS-1:0]     tag_mem  [2][SETS];
  logic [SETS-1:0]         valid0;
  logic [SETS-1:0]         valid1;
  logic [SETS-1:0]         lru;

  logic [TAG_BITS-1:0]     req_tag;
  logic [INDEX_BITS-1:0]   req_idx;
  logic [WORD_BITS-1:0]    req_word;
  logic [TAG_BITS-1:0]     fill_tag;
  logic [INDEX_BITS-1:0]   fill_idx;
  logic                    hit0;
  logic                    hit1;
  logic                    hit_any;
  logic                    hit_way;
  logic [DATA_WIDTH-1:0]   hit_data;
  logic                    victim_sel;
  logic                    flush_req;
  logic                    store_go;
  logic                    fill_last;

  assign req_tag  = cpu_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign req_idx  = cpu_addr[OFFSET_BITS +: INDEX_BITS];
  assign req_word = cpu_addr[BYTE_BITS +: WORD_BITS];
  assign fill_tag = base_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign fill_idx = base_addr[OFFSET_BITS +: INDEX_BITS];

  assign hit0     = valid0[req_idx] && (tag_mem[0][req_idx] == req_tag);
  assign hit1     = valid1[req_idx] && (tag_mem[1][req_idx] == req_tag);
  assign hit_any  = hit0 || hit1;
  assign hit_way  = !hit0;
  assign hit_data = data_mem[hit_way][req_idx][req_word];

  // Fill an empty way before evicting; only a full set consults the LRU bit.
  assign victim_sel = !valid0[req_idx] ? 1'b0 :
                      !valid1[req_idx] ? 1'b1 : lru[req_idx];

  assign flush_req = flush || pending;
  assign store_go  = (state == IDLE) && !flush_req && cpu_valid && cpu_we;
  assign fill_last = (fill_cnt == WORD_BITS'(WPL - 1));

  assign cache_hit  = (state == IDLE) && cpu_valid && hit_any;
  assign mem_we     = store_go;
  assign mem_be     = cpu_be;
  assign mem_w_data = cpu_w_data;

  always_comb begin
    mem_addr = cpu_addr;
    if (state == FILL)
      mem_addr = base_addr + (ADDR_WIDTH'(fill_cnt) << BYTE_BITS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fill_cnt   <= '0;
      sweep      <= '0;
      base_addr  <= '0;
      fill_word  <= '0;
      victim     <= 1'b0;
      pending    <= 1'b0;
      cpu_ready  <= 1'b0;
      cpu_r_data <= '0;
      flush_busy <= 1'b0;
      valid0     <= '0;
      valid1     <= '0;
      lru        <= '0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_req) begin
            state      <= FLUSH;
            sweep      <= '0;
            flush_busy <= 1'b1;
            pending    <= 1'b0;
          end else if (cpu_valid) begin
            if (cpu_we) begin
              cpu_ready <= 1'b1;
              if (hit_any)
                lru[req_idx] <= !hit_way;
            end else if (hit_any) begin
              cpu_r_data   <= hit_data;
              cpu_ready    <= 1'b1;
              lru[req_idx] <= !hit_way;
            end else begin
              base_addr <= {cpu_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
              fill_word <= req_word;
              victim    <= victim_sel;
              fill_cnt  <= '0;
              state     <= FILL;
            end
          end
        end

        FILL: begin
          if (flush)
            pending <= 1'b1;
          if (fill_cnt == fill_word)
            cpu_r_data <= mem_r_data;
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_last) begin
            if (victim)
              valid1[fill_idx] <= 1'b1;
            else
              valid0[fill_idx] <= 1'b1;
            lru[fill_idx] <= !victim;
            cpu_ready     <= 1'b1;
            state         <= IDLE;
          end
        end

        FLUSH: begin
          valid0[sweep] <= 1'b0;
          valid1[sweep] <= 1'b0;
          lru[sweep]    <= 1'b0;
          sweep         <= sweep + 1'b1;
          if (sweep == INDEX_BITS'(SETS - 1)) begin
            state      <= IDLE;
            flush_busy <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (state == FILL) begin
      data_mem[victim][fill_idx][fill_cnt] <= mem_r_data;
      if (fill_last)
        tag_mem[victim][fill_idx] <= fill_tag;
    end else if (store_go && hit_any) begin
      for (int b = 0; b < BYTES; b++)
        if (cpu_be[b])
          data_mem[hit_way][req_idx][req_word][8*b +: 8] <= cpu_w_data[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_cache_2way_mc.sv
// Directed testbench for cache_2way_mc: a byte-enable RAM model behind the
// cache and hand-computed expectations for fills, hits, LRU, stores, flush.
module tb_cache_2way_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_valid;
  logic        cpu_we;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_w_data;
  logic        flush;
  logic [31:0] cpu_r_data;
  logic        cpu_ready;
  logic        cache_hit;
  logic        flush_busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_w_data;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_r_data;

  int vectors = 0;
  int miscompares = 0;

  cache_2way_mc dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_valid  (cpu_valid),
    .cpu_we     (cpu_we),
    .cpu_be     (cpu_be),
    .cpu_addr   (cpu_addr),
    .cpu_w_data (cpu_w_data),
    .flush      (flush),
    .cpu_r_data (cpu_r_data),
    .cpu_ready  (cpu_ready),
    .cache_hit  (cache_hit),
    .flush_busy (flush_busy),
    .mem_addr   (mem_addr),
    .mem_w_data (mem_w_data),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_r_data (mem_r_data)
  );

  always #5 clk = ~clk;

  // Backing RAM: unwritten words read a fixed address-derived pattern.
  logic [31:0]   ram [4096];
  logic [4095:0] written;
  logic          ram_init;
  logic [11:0]   widx;

  function automatic logic [31:0] initWord(input logic [11:0] w);
    logic [31:0] a;
    a = {18'b0, w, 2'b00};
    case (a)
      32'h100: return 32'hAAAA_0100;
      32'h104: return 32'hBBBB_0104;
      32'h108: return 32'hCCCC_0108;
      32'h10C: return 32'hDDDD_010C;
      32'h200: return 32'h1122_3344;
      default: return 32'h5A00_0000 | a;
    endcase
  endfunction

  function automatic logic [31:0] mergeWord(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  assign widx       = mem_addr[13:2];
  assign mem_r_data = written[widx] ? ram[widx] : initWord(widx);

  always @(posedge clk) begin
    if (ram_init) begin
      written <= '0;
    end else if (mem_we) begin
      ram[widx]     <= mergeWord(mem_r_data, mem_w_data, mem_be);
      written[widx] <= 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wdata);
    cpu_valid  = v;
    cpu_we     = we;
    cpu_be     = be;
    cpu_addr   = addr;
    cpu_w_data = wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady(input int start, output int lat);
    lat = start;
    do begin
      tick();
      lat++;
    end while (!cpu_ready && lat < 40);
    checkOutput("ready_seen", {63'b0, cpu_ready}, 64'd1);
  endtask

  task automatic doLoad(input logic [31:0] addr, input logic exp_hit, input logic [31:0] exp_data);
    int lat;
    applyStimulus(1'b1, 1'b0, 4'h0, addr, 32'h0);
    #1;
    checkOutput($sformatf("load_%0h_hit", addr), {63'b0, cache_hit}, {63'b0, exp_hit});
    waitReady(0, lat);
    checkOutput($sformatf("load_%0h_latency", addr), lat, exp_hit ? 64'd1 : 64'd5);
    checkOutput($sformatf("load_%0h_data", addr), {32'b0, cpu_r_data}, {32'b0, exp_data});
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic doStore(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be, input logic exp_hit);
    int lat;
    applyStimulus(1'b1, 1'b1, be, addr, data);
    #1;
    checkOutput($sformatf("store_%0h_hit", addr), {63'b0, cache_hit}, {63'b0, exp_hit});
    checkOutput($sformatf("store_%0h_mem_we", addr), {63'b0, mem_we}, 64'd1);
    waitReady(0, lat);
    checkOutput($sformatf("store_%0h_latency", addr), lat, 64'd1);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    checkOutput($sformatf("store_%0h_mem_we_drop", addr), {63'b0, mem_we}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int n;
    int pulses;

    rst      = 1'b1;
    ram_init = 1'b1;
    flush    = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) tick();
    checkOutput("reset_ready", {63'b0, cpu_ready}, 64'd0);
    checkOutput("reset_rdata", {32'b0, cpu_r_data}, 64'd0);
    checkOutput("reset_flush_busy", {63'b0, flush_busy}, 64'd0);
    rst      = 1'b0;
    ram_init = 1'b0;
    tick();

    $display("[TB] first fill of line 0x100");
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    #1;
    checkOutput("miss100_hit", {63'b0, cache_hit}, 64'd0);
    checkOutput("miss100_idle_addr", {32'b0, mem_addr}, 64'h100);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("miss100_fill_addr%0d", k), {32'b0, mem_addr}, 64'h100 + 64'(4 * k));
      checkOutput($sformatf("miss100_not_ready%0d", k), {63'b0, cpu_ready}, 64'd0);
    end
    tick();
    checkOutput("miss100_ready_c5", {63'b0, cpu_ready}, 64'd1);
    checkOutput("miss100_data", {32'b0, cpu_r_data}, 64'hAAAA_0100);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    doLoad(32'h108, 1'b1, 32'hCCCC_0108);

    $display("[TB] last-word miss");
    doLoad(32'h30C, 1'b0, 32'h5A00_030C);

    $display("[TB] set 0 LRU replacement");
    doLoad(32'h000, 1'b0, 32'h5A00_0000);
    doLoad(32'h800, 1'b0, 32'h5A00_0800);
    doLoad(32'h000, 1'b1, 32'h5A00_0000);
    doLoad(32'h1000, 1'b0, 32'h5A00_1000);
    doLoad(32'h000, 1'b1, 32'h5A00_0000);
    doLoad(32'h800, 1'b0, 32'h5A00_0800);

    $display("[TB] byte-enable store hit and store miss");
    doLoad(32'h200, 1'b0, 32'h1122_3344);
    doStore(32'h200, 32'hAABB_CCDD, 4'b0101, 1'b1);
    doLoad(32'h200, 1'b1, 32'h11BB_33DD);
    doStore(32'h400, 32'h1234_5678, 4'b1111, 1'b0);
    doLoad(32'h400, 1'b0, 32'h1234_5678);

    $display("[TB] flush requested during a fill");
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h500, 32'h0);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    waitReady(3, lat);
    checkOutput("flushfill_latency", lat, 64'd5);
    checkOutput("flushfill_data", {32'b0, cpu_r_data}, 64'h5A00_0500);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    n = 0;
    tick();
    while (flush_busy && n < 300) begin
      n++;
      tick();
    end
    checkOutput("flush_busy_cycles", n, 64'd128);
    doLoad(32'h500, 1'b0, 32'h5A00_0500);
    doLoad(32'h200, 1'b0, 32'h11BB_33DD);

    $display("[TB] reset during a fill");
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h600, 32'h0);
    repeat (3) tick();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 1) rst = 1'b0;
      if (cpu_ready) pulses++;
    end
    checkOutput("rst_fill_no_ready", pulses, 64'd0);
    checkOutput("rst_fill_flush_busy", {63'b0, flush_busy}, 64'd0);
    doLoad(32'h600, 1'b0, 32'h5A00_0600);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
